// File: rtl/uart_rx_os.sv
// 8N1 UART receiver: two-flop synchronizer, 3-sample majority vote at bit
// centre, framing-error pulse and sticky overrun, valid/ack byte handshake.
`timescale 1ns/1ps
module uart_rx_os #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 rx_ferr,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_meta;
  logic                 rxs;
  logic [2:0]           hist;
  logic                 maj;

  assign maj = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

  // hist[0] is the previous rxs, so a start edge is hist[0]=1 with rxs=0;
  // a line held low therefore never retriggers a frame.
  always_ff @(posedge clk) begin
    if (srst) begin
      rx_meta    <= 1'b1;
      rxs        <= 1'b1;
      hist       <= 3'b111;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_overrun <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      hist    <= {hist[1:0], rxs};
      rx_ferr <= 1'b0;

      if (rx_valid && rx_ack)
        rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (hist[0] && !rxs) begin
            state   <= START;
            cnt     <= '0;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (maj) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shreg   <= {maj, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BIT_LAST)
              state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            state   <= IDLE;
            rx_busy <= 1'b0;
            // A same-cycle ack frees the slot, so only an unacked byte overruns.
            if (maj) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              if (rx_valid && !rx_ack)
                rx_overrun <= 1'b1;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed scenarios plus randomized frames
// with baud mismatch, checked against a queue of expected bytes.
`timescale 1ns/1ps
module tb_uart_rx_os;

  localparam real BIT_NS = 160.0;

  logic       clk = 1'b0;
  logic       srst;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;
  logic       rx_overrun;
  logic       rx_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ferr_hi = 0;
  logic [7:0] exp_q[$];

  uart_rx_os #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
    .clk       (clk),
    .srst      (srst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .rx_ferr   (rx_ferr),
    .rx_overrun(rx_overrun),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counts sampled high cycles of rx_ferr; a clean pulse adds exactly one.
  always @(negedge clk) if (rx_ferr) ferr_hi <= ferr_hi + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_val, input real bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_ns);
    end
    rx = stop_val;
    #(bit_ns);
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    checkOutput(tag, {31'd0, rx_valid}, 32'd0);
  endtask

  task automatic do_reset(input int n);
    srst = 1'b1;
    repeat (n) @(negedge clk);
    srst = 1'b0;
  endtask

  // One frame from the line side; the expected byte comes from the model queue.
  task automatic applyStimulus(input logic [7:0] d, input logic stop_val,
                               input real bit_ns, input bit check_lat);
    int   t0;
    int   lat;
    int   ferr0;
    bit   got;
    logic [7:0] exp_byte;
    if (stop_val) exp_q.push_back(d);
    ferr0 = ferr_hi;
    got   = 1'b0;
    lat   = -1;
    @(negedge clk);
    t0 = cyc;
    fork
      send_frame(d, stop_val, bit_ns);
      begin
        for (int i = 0; i < 230 && !got; i++) begin
          @(negedge clk);
          if (rx_valid || rx_ferr) begin
            got = 1'b1;
            lat = cyc - t0;
          end
        end
      end
    join
    rx = 1'b1;
    @(negedge clk);
    checkOutput("frame_seen", {31'd0, got}, 32'd1);
    if (stop_val) begin
      exp_byte = exp_q.pop_front();
      checkOutput("rx_valid", {31'd0, rx_valid}, 32'd1);
      checkOutput("rx_data", {24'd0, rx_data}, {24'd0, exp_byte});
      checkOutput("no_ferr", ferr_hi - ferr0, 32'd0);
      checkOutput("no_overrun", {31'd0, rx_overrun}, 32'd0);
      if (check_lat)
        checkOutput("latency_155pm1", {31'd0, (lat >= 154 && lat <= 156)}, 32'd1);
      do_ack("ack_clears_valid");
    end else begin
      checkOutput("ferr_one_pulse", ferr_hi - ferr0, 32'd1);
      checkOutput("ferr_no_valid", {31'd0, rx_valid}, 32'd0);
    end
  endtask

  initial begin
    int   ferr0;
    int   busy_hits;
    bit   busy_seen;
    bit   idle_again;
    bit   got;
    logic [7:0] d;
    logic [7:0] exp_byte;
    real  err;

    rx     = 1'b1;
    rx_ack = 1'b0;
    srst   = 1'b0;
    @(negedge clk);
    do_reset(3);

    checkOutput("reset_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset_data", {24'd0, rx_data}, 32'd0);
    checkOutput("reset_ferr", {31'd0, rx_ferr}, 32'd0);
    checkOutput("reset_overrun", {31'd0, rx_overrun}, 32'd0);
    checkOutput("reset_busy", {31'd0, rx_busy}, 32'd0);

    // Nominal frame with latency window.
    applyStimulus(8'h55, 1'b1, BIT_NS, 1'b1);

    // Back-to-back frames, each acked as it appears.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    @(negedge clk);
    fork
      begin
        send_frame(8'h00, 1'b1, BIT_NS);
        send_frame(8'hFF, 1'b1, BIT_NS);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          got = 1'b0;
          for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (rx_valid) got = 1'b1;
          end
          checkOutput("b2b_seen", {31'd0, got}, 32'd1);
          exp_byte = exp_q.pop_front();
          checkOutput("b2b_data", {24'd0, rx_data}, {24'd0, exp_byte});
          do_ack("b2b_ack");
        end
      end
    join
    checkOutput("b2b_no_overrun", {31'd0, rx_overrun}, 32'd0);
    repeat (20) @(negedge clk);

    // 3-cycle glitch is rejected as a false start.
    ferr0 = ferr_hi;
    busy_seen  = 1'b0;
    idle_again = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) rx = 1'b1;
      if (rx_busy) busy_seen = 1'b1;
      if (i == 13) idle_again = !rx_busy;
    end
    checkOutput("glitch_busy_pulse", {31'd0, busy_seen}, 32'd1);
    checkOutput("glitch_back_idle", {31'd0, idle_again}, 32'd1);
    repeat (200) @(negedge clk);
    checkOutput("glitch_no_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("glitch_no_ferr", ferr_hi - ferr0, 32'd0);

    // Framing error followed by a held-low line, then a good frame.
    ferr0 = ferr_hi;
    @(negedge clk);
    send_frame(8'hA3, 1'b0, BIT_NS);
    busy_hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_busy) busy_hits++;
    end
    checkOutput("break_ferr_pulse", ferr_hi - ferr0, 32'd1);
    checkOutput("break_no_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("break_no_restart", busy_hits, 32'd0);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    applyStimulus(8'h3C, 1'b1, BIT_NS, 1'b1);

    // Two unacked bytes overrun; overrun survives ack and clears only on reset.
    @(negedge clk);
    send_frame(8'h12, 1'b1, BIT_NS);
    send_frame(8'h34, 1'b1, BIT_NS);
    repeat (5) @(negedge clk);
    checkOutput("ovr_data", {24'd0, rx_data}, 32'h34);
    checkOutput("ovr_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("ovr_flag", {31'd0, rx_overrun}, 32'd1);
    do_ack("ovr_ack_clears");
    repeat (10) @(negedge clk);
    checkOutput("ovr_sticky", {31'd0, rx_overrun}, 32'd1);
    do_reset(3);
    checkOutput("ovr_cleared_by_reset", {31'd0, rx_overrun}, 32'd0);
    checkOutput("reset2_data", {24'd0, rx_data}, 32'd0);

    // Reset during data bit 4, held until the aborted frame has left the line.
    @(negedge clk);
    fork
      send_frame(8'h99, 1'b1, BIT_NS);
      begin
        repeat (88) @(negedge clk);
        checkOutput("abort_busy_midframe", {31'd0, rx_busy}, 32'd1);
        srst = 1'b1;
      end
    join
    @(negedge clk);
    checkOutput("abort_busy_cleared", {31'd0, rx_busy}, 32'd0);
    srst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("abort_no_valid", {31'd0, rx_valid}, 32'd0);
    applyStimulus(8'h66, 1'b1, BIT_NS, 1'b1);
    applyStimulus(8'hAA, 1'b1, BIT_NS, 1'b1);

    // Random bytes, occasional bad stop bit, baud error within +/-2.9%.
    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom);
      err = ($itor($urandom_range(0, 580)) - 290.0) / 10000.0;
      repeat ($urandom_range(1, 30)) @(negedge clk);
      applyStimulus(d, ($urandom_range(0, 7) != 0), BIT_NS * (1.0 + err), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
